// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   DM_DATA_W / DM_ADDR_W : default data and word-address widths of the DM bank
//   DM_*_IDLE             : values driven onto the bank when nothing is granted
//   dm_req_t              : one requester's bank-side request
package dm_arb_pkg;
  localparam int DM_DATA_W = 32;
  localparam int DM_ADDR_W = 9;

  localparam logic                 DM_EN_IDLE   = 1'b1;  // enables are active-low
  localparam logic [DM_ADDR_W-1:0] DM_ADDR_IDLE = '0;
  localparam logic [DM_DATA_W-1:0] DM_DATA_IDLE = '0;
  localparam logic [DM_DATA_W-1:0] DM_BEN_IDLE  = '0;

  typedef struct packed {
    logic                 rd_en;   // active-low
    logic                 wr_en;   // active-low
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] data;
    logic [DM_DATA_W-1:0] bit_en;
  } dm_req_t;
endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle between N_REQ load/store units, the arbiter and the DM macro.
//   slave  : arbiter view (requests/bank read data/clear in; stalls,
//            responses, bank drive and stall counter out)
//   master : requester/bank/testbench view (the mirror image)
interface dm_port_arbiter_if import dm_arb_pkg::*; #(
  parameter int N_REQ         = 4,
  parameter int DATA_WIDTH    = DM_DATA_W,
  parameter int DM_DEPTH_BITS = DM_ADDR_W,
  parameter int STAT_WIDTH    = 16
);
  logic [N_REQ-1:0]               req_rd_en;
  logic [N_REQ-1:0]               req_wr_en;
  logic [N_REQ*DM_DEPTH_BITS-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0]    req_data;
  logic [N_REQ*DATA_WIDTH-1:0]    req_bit_en;
  logic [N_REQ-1:0]               stall;
  logic [N_REQ-1:0]               rsp_valid;
  logic [DATA_WIDTH-1:0]          rsp_rdata;
  logic                           dm_rd_en;
  logic                           dm_wr_en;
  logic [DM_DEPTH_BITS-1:0]       dm_addr;
  logic [DATA_WIDTH-1:0]          dm_data_in;
  logic [DATA_WIDTH-1:0]          dm_bit_en;
  logic [DATA_WIDTH-1:0]          dm_data_out;
  logic                           clear_stats;
  logic [STAT_WIDTH-1:0]          stall_cycles;

  modport slave (
    input  req_rd_en, req_wr_en, req_addr, req_data, req_bit_en, dm_data_out, clear_stats,
    output stall, rsp_valid, rsp_rdata, dm_rd_en, dm_wr_en, dm_addr, dm_data_in, dm_bit_en,
           stall_cycles
  );

  modport master (
    output req_rd_en, req_wr_en, req_addr, req_data, req_bit_en, dm_data_out, clear_stats,
    input  stall, rsp_valid, rsp_rdata, dm_rd_en, dm_wr_en, dm_addr, dm_data_in, dm_bit_en,
           stall_cycles
  );
endinterface

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req_i      : request vector
//   advance_i  : move the pointer past the current winner at the next edge
//   gnt_o      : one-hot grant, first request at or above ptr (mod N_REQ)
//   ptr_o      : current priority pointer
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    ptr_o
);
  logic [PW-1:0] ptr_q, ptr_d, ptr_nxt;
  logic          found;
  int            idx;

  // Rotating scan; the modulo keeps non-power-of-two N_REQ correct.
  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    ptr_nxt = ptr_q;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_nxt    = PW'((idx + 1) % N_REQ);
      end
    end
    ptr_d = (advance_i && found) ? ptr_nxt : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin sharing of one single-port DM bank among N_REQ load/store units.
//   clk, reset : clock, async active-low reset
//   bus        : requests in, stalls/read responses out, bank drive out,
//                bank read data in, stall statistics (see dm_port_arbiter_if)
// The request struct uses the package widths, so DATA_WIDTH/DM_DEPTH_BITS
// are expected to stay at their package defaults.
module dm_port_arbiter import dm_arb_pkg::*; #(
  parameter int N_REQ         = 4,
  parameter int DATA_WIDTH    = DM_DATA_W,
  parameter int DM_DEPTH_BITS = DM_ADDR_W,
  parameter int STAT_WIDTH    = 16
) (
  input  logic              clk,
  input  logic              reset,
  dm_port_arbiter_if.slave  bus
);
  dm_req_t                  lane [N_REQ];
  logic [N_REQ-1:0]         req_v, is_rd, gnt;
  logic [N_REQ-1:0]         rd_owner_q, rd_owner_d;
  logic [STAT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                     rd_n, wr_n;
  logic [DM_DEPTH_BITS-1:0] addr;
  logic [DATA_WIDTH-1:0]    din, ben;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = '{rd_en:  bus.req_rd_en[i],
                       wr_en:  bus.req_wr_en[i],
                       addr:   bus.req_addr[i*DM_DEPTH_BITS +: DM_DEPTH_BITS],
                       data:   bus.req_data[i*DATA_WIDTH +: DATA_WIDTH],
                       bit_en: bus.req_bit_en[i*DATA_WIDTH +: DATA_WIDTH]};
    // Requests are masked while in reset so no grant or stall leaks out.
    assign req_v[i] = reset & ~(lane[i].rd_en & lane[i].wr_en);
    // Write wins when both enables are low: only a pure read gets a response.
    assign is_rd[i] = ~lane[i].rd_en & lane[i].wr_en;
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (reset),
    .req_i     (req_v),
    .advance_i (|req_v),
    .gnt_o     (gnt),
    .ptr_o     ()
  );

  always_comb begin
    rd_n       = DM_EN_IDLE;
    wr_n       = DM_EN_IDLE;
    addr       = DM_ADDR_IDLE;
    din        = DM_DATA_IDLE;
    ben        = DM_BEN_IDLE;
    rd_owner_d = gnt & is_rd;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        addr = lane[i].addr;
        if (!lane[i].wr_en) begin
          wr_n = 1'b0;
          din  = lane[i].data;
          ben  = lane[i].bit_en;
        end else begin
          rd_n = 1'b0;
          ben  = '1;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clear_stats)             cnt_d = '0;
    else if (|bus.stall && ~&cnt_q)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner_q <= '0;
      cnt_q      <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.stall        = req_v & ~gnt;
  assign bus.rsp_valid    = rd_owner_q;
  assign bus.rsp_rdata    = bus.dm_data_out;
  assign bus.dm_rd_en     = rd_n;
  assign bus.dm_wr_en     = wr_n;
  assign bus.dm_addr      = addr;
  assign bus.dm_data_in   = din;
  assign bus.dm_bit_en    = ben;
  assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .DM_DEPTH_BITS(AW), .STAT_WIDTH(SW)) bus ();

  dm_port_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .DM_DEPTH_BITS(AW), .STAT_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0]          rd, wr;
    logic [N-1:0][AW-1:0]  a;
    logic [N-1:0][DW-1:0]  d, m;
    logic [N-1:0]          e_stall, e_rsp;
    logic                  e_drd, e_dwr;
    logic [AW-1:0]         e_addr;
    logic [DW-1:0]         e_din, e_ben;
    logic [SW-1:0]         e_cnt;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  logic [N-1:0]         b_rd, b_wr;
  logic [N-1:0][AW-1:0] b_a;
  logic [N-1:0][DW-1:0] b_d, b_m;
  int errors = 0;
  int checks = 0;
  int rsp_cnt [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_rd_en[i]               = b_rd[i];
      bus.req_wr_en[i]               = b_wr[i];
      bus.req_addr[i*AW +: AW]       = b_a[i];
      bus.req_data[i*DW +: DW]       = b_d[i];
      bus.req_bit_en[i*DW +: DW]     = b_m[i];
    end
  endtask

  task automatic idle_all();
    b_rd = '1; b_wr = '1; b_a = '0; b_d = '0; b_m = '0;
    drive();
  endtask

  task automatic lane(input int k, input int i, input logic rd, input logic wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    tbl[k].rd[i] = rd; tbl[k].wr[i] = wr;
    tbl[k].a[i]  = a;  tbl[k].d[i]  = d; tbl[k].m[i] = m;
  endtask

  task automatic set_exp(input int k, input logic [N-1:0] st, input logic [N-1:0] rv,
                         input logic drd, input logic dwr, input logic [AW-1:0] da,
                         input logic [DW-1:0] din, input logic [DW-1:0] ben, input logic [SW-1:0] cnt);
    tbl[k].e_stall = st; tbl[k].e_rsp = rv; tbl[k].e_drd = drd; tbl[k].e_dwr = dwr;
    tbl[k].e_addr = da;  tbl[k].e_din = din; tbl[k].e_ben = ben; tbl[k].e_cnt = cnt;
  endtask

  initial begin
    bus.clear_stats = 1'b0;
    bus.dm_data_out = 32'hDEADBEEF;

    // ---- table: ptr starts at 0 after reset ----
    for (int k = 0; k < NV; k++) begin
      tbl[k].rd = '1; tbl[k].wr = '1; tbl[k].a = '0; tbl[k].d = '0; tbl[k].m = '0;
    end
    lane(0, 0, 1, 0, 9'h003, 32'h11111111, 32'hFFFF0000);
    lane(0, 2, 1, 0, 9'h007, 32'h22222222, 32'h0000FFFF);
    set_exp(0, 4'b0100, 4'b0000, 1, 0, 9'h003, 32'h11111111, 32'hFFFF0000, 0);
    lane(1, 2, 1, 0, 9'h007, 32'h22222222, 32'h0000FFFF);
    set_exp(1, 4'b0000, 4'b0000, 1, 0, 9'h007, 32'h22222222, 32'h0000FFFF, 1);
    lane(2, 1, 0, 1, 9'h005, 32'h0, 32'h0);
    set_exp(2, 4'b0000, 4'b0000, 0, 1, 9'h005, 32'h0, 32'hFFFFFFFF, 1);
    set_exp(3, 4'b0000, 4'b0010, 1, 1, 9'h000, 32'h0, 32'h0, 1);
    lane(4, 3, 0, 0, 9'h01A, 32'h12, 32'hFF);
    set_exp(4, 4'b0000, 4'b0000, 1, 0, 9'h01A, 32'h12, 32'hFF, 1);
    set_exp(5, 4'b0000, 4'b0000, 1, 1, 9'h000, 32'h0, 32'h0, 1);
    lane(6, 1, 0, 1, 9'h010, 32'hAAAAAAAA, 32'h5555);
    lane(6, 3, 0, 1, 9'h013, 32'h0, 32'h0);
    set_exp(6, 4'b1000, 4'b0000, 0, 1, 9'h010, 32'h0, 32'hFFFFFFFF, 1);
    lane(7, 3, 0, 1, 9'h013, 32'h0, 32'h0);
    lane(7, 0, 0, 1, 9'h020, 32'h0, 32'h0);
    set_exp(7, 4'b0001, 4'b0010, 0, 1, 9'h013, 32'h0, 32'hFFFFFFFF, 2);
    lane(8, 0, 0, 1, 9'h020, 32'h0, 32'h0);
    set_exp(8, 4'b0000, 4'b1000, 0, 1, 9'h020, 32'h0, 32'hFFFFFFFF, 3);
    set_exp(9, 4'b0000, 4'b0001, 1, 1, 9'h000, 32'h0, 32'h0, 3);

    // ---- reset: every requester active while reset is held ----
    b_rd = '0; b_wr = '1; b_a = '0; b_d = '1; b_m = '1;
    drive();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall",     64'(bus.stall), 64'h0);
    chk("rst_dm_rd_en",  64'(bus.dm_rd_en), 64'h1);
    chk("rst_dm_wr_en",  64'(bus.dm_wr_en), 64'h1);
    chk("rst_dm_bit_en", 64'(bus.dm_bit_en), 64'h0);
    chk("rst_dm_addr",   64'(bus.dm_addr), 64'h0);
    chk("rst_cnt",       64'(bus.stall_cycles), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    @(negedge clk);
    idle_all();
    reset = 1'b1;

    // ---- table-driven vectors ----
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      b_rd = tbl[k].rd; b_wr = tbl[k].wr; b_a = tbl[k].a; b_d = tbl[k].d; b_m = tbl[k].m;
      drive();
      #2;
      chk($sformatf("v%0d_stall", k),     64'(bus.stall),        64'(tbl[k].e_stall));
      chk($sformatf("v%0d_rsp_valid", k), 64'(bus.rsp_valid),    64'(tbl[k].e_rsp));
      chk($sformatf("v%0d_rsp_rdata", k), 64'(bus.rsp_rdata),    64'h00000000DEADBEEF);
      chk($sformatf("v%0d_dm_rd_en", k),  64'(bus.dm_rd_en),     64'(tbl[k].e_drd));
      chk($sformatf("v%0d_dm_wr_en", k),  64'(bus.dm_wr_en),     64'(tbl[k].e_dwr));
      chk($sformatf("v%0d_dm_addr", k),   64'(bus.dm_addr),      64'(tbl[k].e_addr));
      chk($sformatf("v%0d_dm_data_in", k),64'(bus.dm_data_in),   64'(tbl[k].e_din));
      chk($sformatf("v%0d_dm_bit_en", k), 64'(bus.dm_bit_en),    64'(tbl[k].e_ben));
      chk($sformatf("v%0d_cnt", k),       64'(bus.stall_cycles), 64'(tbl[k].e_cnt));
    end

    // ---- fairness: reset pointer, all four read for 8 cycles ----
    @(negedge clk);
    idle_all();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      b_rd[i] = 1'b0; b_a[i] = AW'(9'h040 + i);
      rsp_cnt[i] = 0;
    end
    drive();
    for (int k = 0; k < 9; k++) begin
      if (k == 8) idle_all();
      #2;
      if (k < 8) begin
        chk($sformatf("fair%0d_addr", k),  64'(bus.dm_addr), 64'(9'h040 + (k % N)));
        chk($sformatf("fair%0d_stall", k), 64'(bus.stall),   64'(4'hF & ~(4'b0001 << (k % N))));
      end
      chk($sformatf("fair%0d_rsp", k), 64'(bus.rsp_valid),
          (k == 0) ? 64'h0 : 64'(4'b0001 << ((k - 1) % N)));
      for (int i = 0; i < N; i++) rsp_cnt[i] += int'(bus.rsp_valid[i]);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) chk($sformatf("fair_rsp_count%0d", i), 64'(rsp_cnt[i]), 64'd2);
    #2;
    chk("fair_cnt", 64'(bus.stall_cycles), 64'd8);

    // ---- saturation: constant stall from two readers ----
    b_rd = 4'b1100; b_a[0] = 9'h001; b_a[1] = 9'h002;
    drive();
    bus.clear_stats = 1'b1;              // clear must win over a concurrent stall
    @(negedge clk);
    bus.clear_stats = 1'b0;
    #2;
    chk("clr_priority", 64'(bus.stall_cycles), 64'h0);
    repeat (65534) @(negedge clk);
    #2;
    chk("sat_fffe", 64'(bus.stall_cycles), 64'hFFFE);
    @(negedge clk); #2;
    chk("sat_ffff", 64'(bus.stall_cycles), 64'hFFFF);
    repeat (3) @(negedge clk);
    #2;
    chk("sat_hold", 64'(bus.stall_cycles), 64'hFFFF);
    bus.clear_stats = 1'b1;
    @(negedge clk);
    bus.clear_stats = 1'b0;
    idle_all();
    #2;
    chk("sat_clear", 64'(bus.stall_cycles), 64'h0);

    // ---- reset the cycle after a read grant ----
    @(negedge clk);
    b_rd[1] = 1'b0; b_a[1] = 9'h005;
    drive();
    #2;
    chk("mid_grant_rd", 64'(bus.dm_rd_en), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rsp_dropped", 64'(bus.rsp_valid), 64'h0);
    chk("mid_stall",       64'(bus.stall),     64'h0);
    chk("mid_dm_rd_en",    64'(bus.dm_rd_en),  64'h1);
    @(negedge clk);
    idle_all();
    reset = 1'b1;
    #2;
    chk("mid_rsp_after", 64'(bus.rsp_valid), 64'h0);
    @(negedge clk); #2;
    chk("mid_rsp_after2", 64'(bus.rsp_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
